// File: rtl/bird_physics.sv
// bird_physics: vertical-motion engine for the player sprite.
// Fixed-point position/velocity integrated once per frame tick, with gravity,
// flap impulses, a silent ceiling clamp and a sticky ground-hit flag.
module bird_physics #(
   parameter int TICK_DIV  = 500000,
   parameter int ROWS      = 16,
   parameter int FRAC      = 4,
   parameter int START_ROW = 8,
   parameter int GRAVITY   = 3,
   parameter int FLAP_VEL  = 20,
   parameter int VMAX      = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flap,
   input  logic                    game_enable,
   input  logic                    game_reset,
   output logic [$clog2(ROWS)-1:0] bird_row,
   output logic                    tick,
   output logic                    ground_hit
);

   localparam int ROW_W = $clog2(ROWS);
   localparam int Y_W   = ROW_W + FRAC;
   localparam int V_W   = Y_W + 2;
   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [Y_W-1:0]        START_POS = Y_W'(START_ROW << FRAC);
   localparam logic signed [V_W-1:0] MAX_POS_V = V_W'((1 << Y_W) - 1);
   localparam logic signed [V_W-1:0] GRAV_V    = V_W'(GRAVITY);
   localparam logic signed [V_W-1:0] FLAP_V    = V_W'(FLAP_VEL);
   localparam logic signed [V_W-1:0] VMIN_V    = V_W'(-VMAX);
   localparam logic signed [V_W-1:0] ZERO_V    = '0;
   localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TICK_DIV - 1);

   logic [Y_W-1:0]        pos_q, pos_d;
   logic signed [V_W-1:0] vel_q, vel_d;
   logic [CNT_W-1:0]      tick_cnt_q, tick_cnt_d;
   logic                  flap_prev_q, flap_prev_d;
   logic                  flap_pending_q, flap_pending_d;
   logic                  ground_hit_q, ground_hit_d;

   logic                  flap_edge;
   logic                  pending_now;
   logic signed [V_W-1:0] vel_grav;
   logic signed [V_W-1:0] vel_n;
   logic signed [V_W-1:0] p;

   assign tick       = (tick_cnt_q == CNT_LAST);
   assign bird_row   = pos_q[Y_W-1:FRAC];
   assign ground_hit = ground_hit_q;

   // Next-state: free-running tick counter, flap edge capture, per-tick integration.
   always_comb begin
      tick_cnt_d     = tick ? '0 : tick_cnt_q + CNT_W'(1);
      flap_prev_d    = flap;
      flap_pending_d = flap_pending_q;
      pos_d          = pos_q;
      vel_d          = vel_q;
      ground_hit_d   = ground_hit_q;

      flap_edge   = flap & ~flap_prev_q;
      // An edge arriving in the tick cycle itself still counts for that tick.
      pending_now = flap_pending_q | (flap_edge & game_enable);

      vel_grav = vel_q - GRAV_V;
      if (vel_grav < VMIN_V) begin
         vel_grav = VMIN_V;
      end
      vel_n = pending_now ? FLAP_V : vel_grav;
      p     = $signed({2'b00, pos_q}) + vel_n;

      // Pending flaps are consumed by any tick and dropped while the game is paused.
      if (!game_enable || tick) begin
         flap_pending_d = 1'b0;
      end else if (flap_edge) begin
         flap_pending_d = 1'b1;
      end

      if (tick && game_enable && !ground_hit_q) begin
         if (p > MAX_POS_V) begin
            pos_d = '1;
            vel_d = '0;
         end else if ((p <= ZERO_V) && (vel_n < ZERO_V)) begin
            pos_d        = '0;
            vel_d        = '0;
            ground_hit_d = 1'b1;
         end else begin
            pos_d = p[Y_W-1:0];
            vel_d = vel_n;
         end
      end

      // Reinitialise everything except the frame counter.
      if (game_reset) begin
         pos_d          = START_POS;
         vel_d          = '0;
         flap_prev_d    = 1'b0;
         flap_pending_d = 1'b0;
         ground_hit_d   = 1'b0;
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pos_q          <= START_POS;
         vel_q          <= '0;
         tick_cnt_q     <= '0;
         flap_prev_q    <= 1'b0;
         flap_pending_q <= 1'b0;
         ground_hit_q   <= 1'b0;
      end else begin
         pos_q          <= pos_d;
         vel_q          <= vel_d;
         tick_cnt_q     <= tick_cnt_d;
         flap_prev_q    <= flap_prev_d;
         flap_pending_q <= flap_pending_d;
         ground_hit_q   <= ground_hit_d;
      end
   end

endmodule

// File: tb/tb_bird_physics.sv
// Bench for bird_physics with TICK_DIV=4. Stimulus pushes the expected
// post-tick {row, ground_hit, pos} into a queue; the monitor pops and compares
// on the cycle following each tick.
module tb_bird_physics;

   logic       clk;
   logic       reset;
   logic       flap;
   logic       game_enable;
   logic       game_reset;
   logic [3:0] bird_row;
   logic       tick;
   logic       ground_hit;

   int checks = 0;
   int errors = 0;

   logic [12:0] exp_q[$];
   logic [12:0] mon_e;
   logic        tick_prev = 1'b0;

   int ff_pos [0:8] = '{125, 119, 110, 98, 83, 65, 44, 20, 0};
   int fall2_pos [0:7] = '{119, 110, 98, 83, 65, 44, 20, 0};

   bird_physics #(.TICK_DIV(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .flap       (flap),
      .game_enable(game_enable),
      .game_reset (game_reset),
      .bird_row   (bird_row),
      .tick       (tick),
      .ground_hit (ground_hit)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Waits until a negedge at which tick is high, bounded.
   task automatic wait_tick();
      int n = 0;
      @(negedge clk);
      while (!tick && n < 16) begin
         @(negedge clk);
         n++;
      end
      if (!tick) begin
         checks++;
         errors++;
         $display("FAIL tick_timeout: got no tick within %0d cycles expected one", n);
      end
   endtask

   // Queue the expected state after the next tick, then step past it.
   task automatic do_tick(input logic [7:0] pos, input logic gh);
      wait_tick();
      exp_q.push_back({pos[7:4], gh, pos});
      @(negedge clk);
   endtask

   // Monitor: compare on the cycle after each tick while expectations are queued.
   always @(negedge clk) begin
      if (tick_prev && exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("tick_row", int'(bird_row), int'(mon_e[12:9]));
         check("tick_ground_hit", int'(ground_hit), int'(mon_e[8]));
         check("tick_pos", int'(dut.pos_q), int'(mon_e[7:0]));
      end
      tick_prev <= tick;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int first_idx;
      int last_idx;
      int n_ticks;

      reset       = 1'b1;
      flap        = 1'b0;
      game_enable = 1'b0;
      game_reset  = 1'b0;
      repeat (3) @(negedge clk);
      reset       = 1'b0;
      game_enable = 1'b1;

      // Free fall to the ground, then ground_hit stays set.
      for (int i = 0; i < 9; i++) begin
         do_tick(8'(ff_pos[i]), (i == 8));
      end
      do_tick(8'd0, 1'b1);
      do_tick(8'd0, 1'b1);

      // Asynchronous reset mid-count.
      game_enable = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("areset_row", int'(bird_row), 8);
      check("areset_ground_hit", int'(ground_hit), 0);
      check("areset_pos", int'(dut.pos_q), 128);
      @(negedge clk);
      reset = 1'b0;

      // Tick period after release.
      n_ticks   = 0;
      first_idx = -1;
      last_idx  = 0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (tick) begin
            if (n_ticks > 0) check("tick_gap", k - last_idx, 4);
            else first_idx = k;
            last_idx = k;
            n_ticks++;
         end
      end
      check("tick_first", first_idx, 3);
      check("tick_count", n_ticks, 4);

      // Single flap pulse from the start position.
      wait_tick();
      @(negedge clk);
      game_enable = 1'b1;
      flap        = 1'b1;
      @(negedge clk);
      flap = 1'b0;
      do_tick(8'd148, 1'b0);
      do_tick(8'd165, 1'b0);
      do_tick(8'd179, 1'b0);

      // Held flap for 20 cycles gives a single impulse.
      flap = 1'b1;
      do_tick(8'd199, 1'b0);
      do_tick(8'd216, 1'b0);
      do_tick(8'd230, 1'b0);
      do_tick(8'd241, 1'b0);
      do_tick(8'd249, 1'b0);
      flap = 1'b0;
      do_tick(8'd254, 1'b0);

      // game_reset mid-flight.
      game_reset = 1'b1;
      @(negedge clk);
      game_reset = 1'b0;
      check("greset_pos", int'(dut.pos_q), 128);
      check("greset_vel", int'(dut.vel_q), 0);

      // Ceiling: a flap before every tick.
      for (int i = 0; i < 6; i++) begin
         flap = 1'b1;
         @(negedge clk);
         flap = 1'b0;
         do_tick(8'(148 + 20 * i), 1'b0);
      end
      flap = 1'b1;
      @(negedge clk);
      flap = 1'b0;
      do_tick(8'd255, 1'b0);
      check("ceil_vel", int'(dut.vel_q), 0);

      // Enable gating.
      game_enable = 1'b0;
      game_reset  = 1'b1;
      @(negedge clk);
      game_reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         flap = 1'b1;
         @(negedge clk);
         flap = 1'b0;
         do_tick(8'd128, 1'b0);
      end
      flap = 1'b1;
      @(negedge clk);
      game_enable = 1'b1;
      do_tick(8'd125, 1'b0);
      flap = 1'b0;

      // Fall to the ground again, then game_reset.
      for (int i = 0; i < 8; i++) begin
         do_tick(8'(fall2_pos[i]), (i == 7));
      end
      do_tick(8'd0, 1'b1);
      game_reset = 1'b1;
      @(negedge clk);
      game_reset = 1'b0;
      check("greset2_row", int'(bird_row), 8);
      check("greset2_ground_hit", int'(ground_hit), 0);
      check("greset2_vel", int'(dut.vel_q), 0);
      check("greset2_pos", int'(dut.pos_q), 128);

      // game_reset coincident with a tick and a flap edge.
      wait_tick();
      game_reset = 1'b1;
      flap       = 1'b1;
      exp_q.push_back({4'd8, 1'b0, 8'd128});
      @(negedge clk);
      game_reset = 1'b0;
      flap       = 1'b0;
      check("coinc_vel", int'(dut.vel_q), 0);
      do_tick(8'd125, 1'b0);

      repeat (2) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
